// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit geometry, phase encoding and hop-field helper for the input VC buffer
package noc_pkg;

  localparam int FLIT_W_DEF  = 64;
  localparam int HOP_LSB_DEF = 48;
  localparam int HOP_W       = 8;

  // Phase value of the state input: which VC the link side is filling.
  localparam logic PHASE_EVEN = 1'b0;  // link -> VC1, arbiter <- VC2
  localparam logic PHASE_ODD  = 1'b1;  // link -> VC2, arbiter <- VC1

  function automatic logic [HOP_W-1:0] hop_dec(input logic [HOP_W-1:0] hop);
    return (hop == '0) ? '0 : hop - 1'b1;
  endfunction

endpackage

// File: rtl/input_vc_buffer_if.sv
// rtl/input_vc_buffer_if.sv - upstream link handshake (send / data / ready) between sender and VC buffer
interface input_vc_buffer_if #(
  parameter int FLIT_W = noc_pkg::FLIT_W_DEF
);

  logic              link_si;
  logic [FLIT_W-1:0] link_di;
  logic              link_ri;

  modport master (output link_si, output link_di, input  link_ri);
  modport slave  (input  link_si, input  link_di, output link_ri);

endinterface

// File: rtl/vc_slot_pair.sv
// rtl/vc_slot_pair.sv - two-slot storage for one virtual channel with fill and grant-clear logic
module vc_slot_pair
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_sel,
  input  logic              grant1,
  input  logic              grant2,
  output logic              req1,
  output logic              req2,
  output logic [FLIT_W-1:0] buf1,
  output logic [FLIT_W-1:0] buf2,
  output logic [1:0]        count,
  output logic              has_free
);

  logic              v1_q, v1_d, v2_q, v2_d;
  logic [FLIT_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    d1_d = d1_q;
    d2_d = d2_q;
    // wr_en is only raised while this VC is the write side, so fill and
    // grant-clear never target the same pair in one cycle.
    if (wr_en) begin
      if (!v1_q) begin
        v1_d = 1'b1;
        d1_d = wr_data;
      end else begin
        v2_d = 1'b1;
        d2_d = wr_data;
      end
    end
    if (rd_sel && grant1 && v1_q) v1_d = 1'b0;
    if (rd_sel && grant2 && v2_q) v2_d = 1'b0;
    cnt_d = {1'b0, v1_d} + {1'b0, v2_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      d1_q  <= '0;
      d2_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      cnt_q <= cnt_d;
    end
  end

  assign req1     = v1_q;
  assign req2     = v2_q;
  assign buf1     = d1_q;
  assign buf2     = d2_q;
  assign count    = cnt_q;
  assign has_free = !(v1_q && v2_q);

endmodule

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - ping-pong two-VC input buffer; INPUT_VC_BUFFER_HOP_DEC_EN enables hop decrement on capture
module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int HOP_LSB = HOP_LSB_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 state,
  input_vc_buffer_if.slave     link,
  output logic                 vc_1_req1,
  output logic                 vc_1_req2,
  output logic                 vc_2_req1,
  output logic                 vc_2_req2,
  output logic [FLIT_W-1:0]    vc_1_req_buffer_1,
  output logic [FLIT_W-1:0]    vc_1_req_buffer_2,
  output logic [FLIT_W-1:0]    vc_2_req_buffer_1,
  output logic [FLIT_W-1:0]    vc_2_req_buffer_2,
  input  logic                 flag_vc1_req1,
  input  logic                 flag_vc1_req2,
  input  logic                 flag_vc2_req1,
  input  logic                 flag_vc2_req2,
  output logic [1:0]           vc1_count,
  output logic [1:0]           vc2_count
);

`ifdef INPUT_VC_BUFFER_HOP_DEC_EN
  localparam bit HOP_DEC_EN = 1'b1;
`else
  localparam bit HOP_DEC_EN = 1'b0;
`endif

  logic              wr_vc1;
  logic              free1, free2;
  logic              xfer;
  logic [FLIT_W-1:0] flit_in;

  assign wr_vc1       = (state == PHASE_EVEN);
  assign link.link_ri = reset && (wr_vc1 ? free1 : free2);
  assign xfer         = link.link_si && link.link_ri;

  always_comb begin
    flit_in = link.link_di;
    if (HOP_DEC_EN) flit_in[HOP_LSB +: HOP_W] = hop_dec(link.link_di[HOP_LSB +: HOP_W]);
  end

  vc_slot_pair #(.FLIT_W(FLIT_W)) u_vc1 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (xfer && wr_vc1),
    .wr_data  (flit_in),
    .rd_sel   (!wr_vc1),
    .grant1   (flag_vc1_req1),
    .grant2   (flag_vc1_req2),
    .req1     (vc_1_req1),
    .req2     (vc_1_req2),
    .buf1     (vc_1_req_buffer_1),
    .buf2     (vc_1_req_buffer_2),
    .count    (vc1_count),
    .has_free (free1)
  );

  vc_slot_pair #(.FLIT_W(FLIT_W)) u_vc2 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (xfer && !wr_vc1),
    .wr_data  (flit_in),
    .rd_sel   (wr_vc1),
    .grant1   (flag_vc2_req1),
    .grant2   (flag_vc2_req2),
    .req1     (vc_2_req1),
    .req2     (vc_2_req2),
    .buf1     (vc_2_req_buffer_1),
    .buf2     (vc_2_req_buffer_2),
    .count    (vc2_count),
    .has_free (free2)
  );

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - directed scoreboard bench for input_vc_buffer
module tb_input_vc_buffer;

  typedef struct packed {
    logic [3:0]  req;
    logic [63:0] b11;
    logic [63:0] b12;
    logic [63:0] b21;
    logic [63:0] b22;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic        ri;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic state = 1'b0;
  logic f1r1 = 1'b0, f1r2 = 1'b0, f2r1 = 1'b0, f2r2 = 1'b0;
  logic v1r1, v1r2, v2r1, v2r2;
  logic [63:0] b11, b12, b21, b22;
  logic [1:0] c1, c2;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  input_vc_buffer_if #(.FLIT_W(64)) link_if ();

  input_vc_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .state             (state),
    .link              (link_if.slave),
    .vc_1_req1         (v1r1),
    .vc_1_req2         (v1r2),
    .vc_2_req1         (v2r1),
    .vc_2_req2         (v2r2),
    .vc_1_req_buffer_1 (b11),
    .vc_1_req_buffer_2 (b12),
    .vc_2_req_buffer_1 (b21),
    .vc_2_req_buffer_2 (b22),
    .flag_vc1_req1     (f1r1),
    .flag_vc1_req2     (f1r2),
    .flag_vc2_req1     (f2r1),
    .flag_vc2_req2     (f2r2),
    .vc1_count         (c1),
    .vc2_count         (c2)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] F0 = 64'h1fffffff00000000;
  localparam logic [63:0] F1 = 64'h17ffffff00000000;
  localparam logic [63:0] F2 = 64'h13ffffff00000000;
  localparam logic [63:0] F3 = 64'h11ffffff00000000;
  localparam logic [63:0] FA = 64'h0103456789abcdef;  // hop 8'h03
  localparam logic [63:0] FB = 64'hfe00ba9876543210;  // hop 8'h00
  localparam logic [63:0] FC = 64'h00ff00ff00ff00ff;
  localparam logic [63:0] FD = 64'hcafe004212345678;

  function automatic logic [63:0] s(input logic [63:0] x);
    logic [63:0] r;
    r = x;
`ifdef INPUT_VC_BUFFER_HOP_DEC_EN
    if (r[55:48] != 8'h00) r[55:48] = r[55:48] - 8'h01;
`endif
    return r;
  endfunction

  function automatic exp_t mk(input logic [3:0] req, input logic [63:0] e11, e12, e21, e22,
                              input logic [1:0] ec1, ec2, input logic eri);
    exp_t e;
    e.req = req; e.b11 = e11; e.b12 = e12; e.b21 = e21; e.b22 = e22;
    e.c1 = ec1; e.c2 = ec2; e.ri = eri;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Inputs set here act on the coming edge; e is what the outputs show now.
  task automatic cyc(input logic rst, input logic st, input logic si, input logic [63:0] di,
                     input logic [3:0] fl, input exp_t e);
    @(posedge clk);
    #1;
    reset = rst;
    state = st;
    link_if.link_si = si;
    link_if.link_di = di;
    {f1r1, f1r2, f2r1, f2r2} = fl;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req", {60'd0, v1r1, v1r2, v2r1, v2r2}, {60'd0, e.req});
      chk("buf11", b11, e.b11);
      chk("buf12", b12, e.b12);
      chk("buf21", b21, e.b21);
      chk("buf22", b22, e.b22);
      chk("vc1_count", {62'd0, c1}, {62'd0, e.c1});
      chk("vc2_count", {62'd0, c2}, {62'd0, e.c2});
      chk("link_ri", {63'd0, link_if.link_ri}, {63'd0, e.ri});
    end
  end

  exp_t z;

  initial begin
    link_if.link_si = 1'b0;
    link_if.link_di = '0;
    z = mk(4'b0000, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0);

    cyc(0, 0, 1, 64'hdeadbeefdeadbeef, 4'b0000, z);
    cyc(1, 0, 1, F0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0, 0, 1));
    cyc(1, 0, 0, 0,  4'b0000, mk(4'b1000, s(F0), 0, 0, 0, 1, 0, 1));
    cyc(1, 1, 0, 0,  4'b1000, mk(4'b1000, s(F0), 0, 0, 0, 1, 0, 1));
    cyc(1, 0, 1, F1, 4'b0000, mk(4'b0000, s(F0), 0, 0, 0, 0, 0, 1));
    cyc(1, 0, 1, F2, 4'b0000, mk(4'b1000, s(F1), 0, 0, 0, 1, 0, 1));
    cyc(1, 0, 1, F3, 4'b0000, mk(4'b1100, s(F1), s(F2), 0, 0, 2, 0, 0));
    cyc(1, 1, 0, 0,  4'b1110, mk(4'b1100, s(F1), s(F2), 0, 0, 2, 0, 1));
    cyc(1, 0, 1, FA, 4'b0000, mk(4'b0000, s(F1), s(F2), 0, 0, 0, 0, 1));
    cyc(1, 0, 1, FB, 4'b1000, mk(4'b1000, s(FA), s(F2), 0, 0, 1, 0, 1));
    cyc(1, 1, 1, FC, 4'b0100, mk(4'b1100, s(FA), s(FB), 0, 0, 2, 0, 1));
    cyc(1, 1, 0, 0,  4'b0000, mk(4'b1010, s(FA), s(FB), s(FC), 0, 1, 1, 1));

    // Asynchronous reset between edges with both VCs occupied.
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(z);

    cyc(0, 1, 1, FD, 4'b0000, z);
    cyc(1, 1, 1, FD, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0, 0, 1));
    cyc(1, 1, 0, 0,  4'b0000, mk(4'b0010, 0, 0, s(FD), 0, 0, 1, 1));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
